// File: rtl/fft_loader_pkg.sv
// Shared constants and FSM state encoding for the fft_loader feeder.
package fft_loader_pkg;

  localparam int FFT_LOGN = 3;
  localparam int FFT_N    = 1 << FFT_LOGN;
  localparam int FFT_DW   = 128;
  localparam int FFT_AW   = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    KICK = 3'd2,
    ARM  = 3'd3,
    RUN  = 3'd4
  } state_e;

endpackage

// File: rtl/fft_loader_bit_reverse.sv
// Combinational bit-order reversal used to permute sample addresses.
module bit_reverse #(
  parameter int W = 3
) (
  input  logic [W-1:0] in_bits,
  output logic [W-1:0] out_bits
);

  always_comb begin
    out_bits = '0;
    for (int i = 0; i < W; i++) begin
      out_bits[i] = in_bits[W-1-i];
    end
  end

endmodule

// File: rtl/fft_loader.sv
// Loads one N-sample frame into the fft core memory, kicks the core, waits for completion.
// Optional FFT_LOADER_BITREV_EN: loader writes in bit-reversed address order itself.
module fft_loader
  import fft_loader_pkg::*;
#(
  parameter int LOGN = FFT_LOGN,
  parameter int DW   = FFT_DW,
  parameter int AW   = FFT_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          fft_busy,
  output logic          fft_sig,
  output logic          fft_we,
  output logic          fft_rev,
  output logic [AW-1:0] fft_addr,
  output logic [DW-1:0] fft_din,
  output logic          loading,
  output logic          frame_done
);

  localparam int N = 1 << LOGN;
  localparam logic [LOGN:0] LAST = (LOGN + 1)'(N - 1);

  state_e        state_q, state_d;
  logic [LOGN:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          fft_sig_q, fft_sig_d;
  logic          fft_we_q, fft_we_d;
  logic          fft_rev_q, fft_rev_d;
  logic [AW-1:0] fft_addr_q, fft_addr_d;
  logic [DW-1:0] fft_din_q, fft_din_d;
  logic          loading_q, loading_d;
  logic          frame_done_q, frame_done_d;
  logic [LOGN-1:0] addr_idx;

`ifdef FFT_LOADER_BITREV_EN
  bit_reverse #(.W(LOGN)) u_bit_reverse (
    .in_bits  (count_q[LOGN-1:0]),
    .out_bits (addr_idx)
  );
`else
  assign addr_idx = count_q[LOGN-1:0];
`endif

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    fft_sig_d    = 1'b0;
    fft_we_d     = 1'b0;
    fft_addr_d   = fft_addr_q;
    fft_din_d    = fft_din_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        if (in_valid && in_ready_q) begin
          fft_we_d   = 1'b1;
          fft_addr_d = AW'(addr_idx);
          fft_din_d  = in_data;
          count_d    = count_q + 1'b1;
          if (count_q == LAST) begin
            state_d = KICK;
          end
        end
      end
      KICK: begin
        fft_sig_d = 1'b1;
        state_d   = ARM;
      end
      ARM: begin
        if (fft_busy) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!fft_busy) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready/loading are registered off the next state so they line up with LOAD exactly.
    in_ready_d = (state_d == LOAD);
    loading_d  = (state_d == LOAD);
`ifdef FFT_LOADER_BITREV_EN
    fft_rev_d  = 1'b0;
`else
    fft_rev_d  = fft_we_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
      fft_sig_q    <= 1'b0;
      fft_we_q     <= 1'b0;
      fft_rev_q    <= 1'b0;
      fft_addr_q   <= '0;
      fft_din_q    <= '0;
      loading_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      fft_sig_q    <= fft_sig_d;
      fft_we_q     <= fft_we_d;
      fft_rev_q    <= fft_rev_d;
      fft_addr_q   <= fft_addr_d;
      fft_din_q    <= fft_din_d;
      loading_q    <= loading_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign fft_sig    = fft_sig_q;
  assign fft_we     = fft_we_q;
  assign fft_rev    = fft_rev_q;
  assign fft_addr   = fft_addr_q;
  assign fft_din    = fft_din_q;
  assign loading    = loading_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_loader.sv
// Directed bench for fft_loader: reset, back-to-back and gapped frames, core handshake, mid-load reset.
module tb_fft_loader;
  import fft_loader_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         fft_busy;
  logic         fft_sig;
  logic         fft_we;
  logic         fft_rev;
  logic [31:0]  fft_addr;
  logic [127:0] fft_din;
  logic         loading;
  logic         frame_done;

  int numCompared   = 0;
  int numMismatched = 0;
  int revTab [8]    = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .fft_busy   (fft_busy),
    .fft_sig    (fft_sig),
    .fft_we     (fft_we),
    .fft_rev    (fft_rev),
    .fft_addr   (fft_addr),
    .fft_din    (fft_din),
    .loading    (loading),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [127:0] d, input logic b);
    start    = s;
    in_valid = v;
    in_data  = d;
    fft_busy = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] sampleWord(input int k);
    logic [63:0] re;
    re = 64'(k);
    return {re, re ^ 64'hA5A5_5A5A_0F0F_F0F0};
  endfunction

  function automatic logic [31:0] expAddr(input int idx);
`ifdef FFT_LOADER_BITREV_EN
    return 32'(revTab[idx]);
`else
    return 32'(idx);
`endif
  endfunction

  function automatic logic expRev();
`ifdef FFT_LOADER_BITREV_EN
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic checkAllZero(input string where);
    checkOutput({where, "_in_ready"}, in_ready, 0);
    checkOutput({where, "_sig"}, fft_sig, 0);
    checkOutput({where, "_we"}, fft_we, 0);
    checkOutput({where, "_rev"}, fft_rev, 0);
    checkOutput({where, "_addr"}, fft_addr, 0);
    checkOutput({where, "_din"}, fft_din, 0);
    checkOutput({where, "_loading"}, loading, 0);
    checkOutput({where, "_frame_done"}, frame_done, 0);
  endtask

  task automatic loadFrame(input bit gapped);
    int   k        = 0;
    int   wrIdx    = 0;
    int   sigCount = 0;
    int   lastWe   = -10;
    int   sigCyc   = -1;
    logic acceptedNow;
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    tick;
    checkOutput("ready_after_start", in_ready, 1);
    checkOutput("loading_after_start", loading, 1);
    for (int cyc = 0; cyc < 40; cyc++) begin
      logic drv;
      drv = gapped ? (cyc % 2 == 0) : 1'b1;
      applyStimulus(1'b0, drv, sampleWord(k), 1'b0);
      acceptedNow = drv && (k < N);
      tick;
      checkOutput("we", fft_we, acceptedNow);
      if (acceptedNow) k++;
      checkOutput("ready", in_ready, k < N);
      checkOutput("loading", loading, k < N);
      if (fft_we) begin
        if (wrIdx >= N) begin
          checkOutput("extra_write", wrIdx, N - 1);
        end else begin
          checkOutput("addr", fft_addr, expAddr(wrIdx));
          checkOutput("din", fft_din, sampleWord(wrIdx));
          checkOutput("rev", fft_rev, expRev());
        end
        wrIdx++;
        lastWe = cyc;
      end
      if (fft_sig) begin
        sigCount++;
        checkOutput("sig_after_last_write", cyc - lastWe, 1);
        checkOutput("sig_writes", wrIdx, N);
        if (sigCyc < 0) sigCyc = cyc;
      end
      if (sigCyc >= 0 && cyc >= sigCyc + 3) break;
    end
    checkOutput("sig_count", sigCount, 1);
    checkOutput("write_count", wrIdx, N);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic runHandshake(input int idleCycles, input int busyCycles);
    for (int i = 0; i < idleCycles; i++) begin
      applyStimulus(i == 1, 1'b1, sampleWord(50), 1'b0);
      tick;
      checkOutput("arm_ready", in_ready, 0);
      checkOutput("arm_done", frame_done, 0);
      checkOutput("arm_we", fft_we, 0);
      checkOutput("arm_sig", fft_sig, 0);
    end
    for (int i = 0; i < busyCycles; i++) begin
      applyStimulus(i == 2, 1'b1, sampleWord(60), 1'b1);
      tick;
      checkOutput("run_ready", in_ready, 0);
      checkOutput("run_done", frame_done, 0);
      checkOutput("run_we", fft_we, 0);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    tick;
    checkOutput("frame_done_pulse", frame_done, 1);
    tick;
    checkOutput("frame_done_end", frame_done, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, sampleWord(70), 1'b0);
      tick;
      checkOutput("idle_ready", in_ready, 0);
      checkOutput("idle_we", fft_we, 0);
      checkOutput("idle_loading", loading, 0);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, sampleWord(9), 1'b0);
    tick;
    checkAllZero("rst1");
    tick;
    checkAllZero("rst2");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, sampleWord(9), 1'b0);
    tick;
    checkOutput("post_rst_ready", in_ready, 0);
    checkOutput("post_rst_we", fft_we, 0);

    $display("[TB] back-to-back frame");
    loadFrame(1'b0);
    runHandshake(5, 20);

    $display("[TB] gapped frame");
    loadFrame(1'b1);
    runHandshake(1, 3);

    $display("[TB] reset during load");
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    tick;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, sampleWord(i), 1'b0);
      tick;
    end
    checkOutput("midload_we", fft_we, 1);
    checkOutput("midload_addr", fft_addr, expAddr(2));
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, sampleWord(3), 1'b0);
    tick;
    checkAllZero("midrst");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick;
      checkOutput("midrst_sig", fft_sig, 0);
      checkOutput("midrst_done", frame_done, 0);
      checkOutput("midrst_we", fft_we, 0);
    end
    loadFrame(1'b0);
    runHandshake(2, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/fft_loader.md
Name: fft_loader

Overview:
- Upstream feeder for the fft core.
- Accepts a valid/ready stream of complex samples, each 128 bits: {real[63:0], imag[63:0]}, IEEE-754 double.
- Writes one frame of N = 2^LOGN samples into the core's sample memory through its we/addr/din port, then pulses sig to launch the transform.
- Holds off further input until the core reports completion, then signals frame_done.

Parameters:
LOGN, 3, log2 of frame length N; equals `logN from top.vh
DW, 128, sample width (64b real in upper half, 64b imag in lower half)
AW, 32, width of the core address bus

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle request to load and run one frame
in_valid  in  1  input sample valid
in_ready  out  1  loader can accept a sample
in_data  in  DW  input sample
fft_busy  in  1  core busy flag (core internal busy, brought out)
fft_sig  out  1  start pulse to the core
fft_we  out  1  core memory write enable
fft_rev  out  1  core bit-reverse select
fft_addr  out  AW  core memory address
fft_din  out  DW  core write data
loading  out  1  high while the loader is in LOAD
frame_done  out  1  one-cycle pulse when the core finishes the frame

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE, count=0.
  - All outputs 0: in_ready, fft_sig, fft_we, fft_rev, fft_addr, fft_din, loading, frame_done.
- All outputs are registered.
- States:
  - IDLE: in_ready=0. start=1 -> LOAD, count=0. in_valid is ignored in IDLE.
  - LOAD: in_ready=1, loading=1.
    - Accepted beat: in_valid & in_ready at edge t.
    - At t+1: fft_we=1, fft_addr=address(count), fft_din=in_data captured at t.
    - count increments on each accepted beat.
    - Beat with count==N-1 accepted -> in_ready drops on the next cycle; state -> KICK.
    - Cycles with no accepted beat -> fft_we=0 on the next cycle; fft_addr/fft_din hold.
  - KICK: fft_we=0 and fft_sig=1 for exactly one cycle, on the cycle after the last write. State -> ARM.
  - ARM: wait for fft_busy=1, then -> RUN. No timeout.
  - RUN: wait for fft_busy=0, then frame_done=1 for one cycle and state -> IDLE.
- start while not IDLE: ignored. No queuing.
- count width is LOGN+1. Wrap is impossible because LOAD exits at N-1.
- fft_addr is zero-extended to AW.
- Reset in any state: immediate return to IDLE with reset values. A partial frame is discarded, and no fft_sig or frame_done is generated.
- Throughput: one sample per cycle in LOAD. Earliest fft_sig is N+2 cycles after start.

Optional Feature:
- Macro: FFT_LOADER_BITREV_EN.
- Defined:
  - address(count) = bit-reverse of count[LOGN-1:0] (e.g. N=8: 1->4, 3->6).
  - fft_rev is held 0; the loader delivers bit-reversed order itself.
- Undefined:
  - address(count) = count.
  - fft_rev=1 whenever fft_we=1, so the core applies its own reversal.

Decomposition:
- Shared package/header (top.vh): `logN, N, DW, and state encodings IDLE=0, LOAD=1, KICK=2, ARM=3, RUN=4.
- One sub-module: reuse the existing bit_reverse for the address permutation (instantiated only under FFT_LOADER_BITREV_EN).
- FSM, counter and output registers live in fft_loader.

Test Plan:
1. Reset: drive rst=1 for 2 cycles with in_valid=1 and start=1 -> all outputs 0 and in_ready=0 throughout; state IDLE after rst falls.
2. Back-to-back load (N=8, macro off): start, then in_data=k for k=0..7 on consecutive cycles.
   - Expect fft_we=1 for 8 consecutive cycles, fft_addr 0..7, fft_din=k, fft_rev=1.
   - Then fft_sig=1 for exactly 1 cycle, with fft_we=0 on that cycle.
3. Gapped input: in_valid toggles 1,0,1,0... -> exactly 8 writes, with fft_we=0 on gap cycles and addresses still 0..7 in order; one fft_sig.
4. Handshake: after fft_sig, hold fft_busy=0 for 5 cycles, then 1 for 20, then 0.
   - Expect in_ready=0 throughout and start ignored.
   - Expect frame_done pulse 1 cycle after fft_busy falls, then IDLE.
5. Reset mid-load: rst=1 after 3 accepted samples -> fft_we=0, in_ready=0 next cycle; no fft_sig ever. A fresh start then writes addr 0..7 again.
6. Macro on (N=8): samples 0..7 -> fft_addr sequence 0,4,2,6,1,5,3,7 with fft_rev=0.
